// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, data width and parity rule.
// Imported by the transmitter, the receiver and the bit timer.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_GUARD  = 3'd5;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(
    input logic [DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses on wrap.
// Restart forces the count back to zero so a new frame starts aligned.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 3
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Enable,
  input  logic i_Restart,
  output logic o_Wrap
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] count;

  assign o_Wrap = i_Enable && (count == LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      count <= '0;
    end else if (i_Restart || !i_Enable || o_Wrap) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data LSB-first, even parity, stop(s), guard.
// A one-deep holding register queues the next byte during a frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [2:0]           idx;
  logic [2:0]           idx_nx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic                 parity;
  logic                 stop_cnt;
  logic                 serial;
  logic                 wrap;
  logic                 launch;

  assign idx_nx = idx + 3'd1;

  // Launch from idle, or straight out of the guard bit with no gap.
  assign launch = hold_full &&
    ((state == ST_IDLE) || ((state == ST_GUARD) && wrap));

  assign o_Tx_Ready  = !hold_full;
  assign o_Tx_Active = (state != ST_IDLE);
  assign o_Tx_Serial = serial;
  assign o_Tx_Done   = (state == ST_GUARD) && wrap;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Enable (state != ST_IDLE),
    .i_Restart(launch),
    .o_Wrap   (wrap)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      parity    <= 1'b0;
      stop_cnt  <= 1'b0;
      serial    <= 1'b1;
    end else begin
      if (i_Tx_DV && !hold_full) begin
        hold      <= i_Tx_Byte;
        hold_full <= 1'b1;
      end
      if (launch) begin
        shift     <= hold;
        parity    <= even_parity(hold);
        hold_full <= 1'b0;
        state     <= ST_START;
        idx       <= '0;
        serial    <= 1'b0;
      end else if (wrap) begin
        unique case (1'b1)
          (state == ST_START): begin
            state  <= ST_DATA;
            idx    <= '0;
            serial <= shift[0];
          end
          (state == ST_DATA): begin
            if (idx == 3'd7) begin
              state  <= ST_PARITY;
              serial <= parity;
            end else begin
              idx    <= idx_nx;
              serial <= shift[idx_nx];
            end
          end
          (state == ST_PARITY): begin
            state    <= ST_STOP;
            stop_cnt <= 1'b0;
            serial   <= 1'b1;
          end
          (state == ST_STOP): begin
            serial <= 1'b1;
            if (stop_cnt == STOP_LAST) begin
              state <= ST_GUARD;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
          (state == ST_GUARD): begin
            state  <= ST_IDLE;
            serial <= 1'b1;
          end
          default: begin
            state  <= ST_IDLE;
            serial <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
